memrequest_bram_responder: RTL and testbench

- Behavioural/BRAM-backed responder for the UberDDR3 memrequest interface, taking the controller's side of the link.
- Lets the DRAM traffic path (audio sample load, audio reads, video frame writes and reads) be brought up and simulated without the DDR3 PHY.
- Accepts one request per cycle, applies writes to internal memory and returns in-order completions after a fixed latency.
- Optionally injects periodic refresh stalls on memrequest_busy to stress initiators.

---
 rtl/memrequest_bram_responder.sv | 137 +++++++++++++
 tb/tb_memrequest_bram_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/memrequest_bram_responder.sv
// rtl/memrequest_bram_responder.sv - BRAM-backed memrequest responder with fixed-latency in-order completions
// Optional build macro: REFRESH_STALL_EN (periodic refresh stalls on memrequest_busy)
module memrequest_bram_responder #(
  parameter int MEM_ADDR_BITS    = 17,
  parameter int LATENCY          = 4,
  parameter int MAX_OUTSTANDING  = 8,
  parameter int REFRESH_INTERVAL = 1000,
  parameter int REFRESH_CYCLES   = 20
) (
  input  logic         clk_dram_ctrl,
  input  logic         rst_dram_ctrl_n,
  input  logic [23:0]  memrequest_addr,
  input  logic         memrequest_en,
  input  logic [127:0] memrequest_write_data,
  input  logic         memrequest_write_enable,
  output logic [127:0] memrequest_resp_data,
  output logic         memrequest_complete,
  output logic         memrequest_busy,
  output logic [3:0]   outstanding_count,
  output logic         protocol_err
);

  logic [127:0]             r_mem [2**MEM_ADDR_BITS];
  logic [127:0]             r_data [LATENCY];
  logic [LATENCY-1:0]       r_valid;
  logic [LATENCY-1:0]       r_wr;
  logic [3:0]               r_outstanding;
  logic                     r_protocol_err;

  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic                     w_busy;
  logic                     w_accept;
  logic                     w_complete;
  logic                     w_refresh_active;

  // Upper address bits are ignored so accesses alias modulo the memory depth.
  assign w_idx = memrequest_addr[MEM_ADDR_BITS-1:0];

  generate
    if (MEM_ADDR_BITS < 24) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^memrequest_addr[23:MEM_ADDR_BITS];
    end
  endgenerate

`ifdef REFRESH_STALL_EN
  logic [31:0] r_refresh_cnt;
  logic        r_refresh_armed;

  // Free-running refresh timer; the first stall only begins after one full interval from reset release.
  always_ff @(posedge clk_dram_ctrl) begin
    if (!rst_dram_ctrl_n) begin
      r_refresh_cnt   <= '0;
      r_refresh_armed <= 1'b0;
    end else begin
      if (r_refresh_cnt == 32'(REFRESH_INTERVAL - 1)) begin
        r_refresh_cnt   <= '0;
        r_refresh_armed <= 1'b1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 32'd1;
      end
    end
  end

  assign w_refresh_active = r_refresh_armed && (r_refresh_cnt < 32'(REFRESH_CYCLES));
`else
  logic w_unused_refresh;
  assign w_unused_refresh = (REFRESH_INTERVAL > 0) ^ (REFRESH_CYCLES > 0);
  assign w_refresh_active = 1'b0;
`endif

  // Busy depends only on reset and registered state, never on memrequest_en.
  assign w_busy     = !rst_dram_ctrl_n
                   || (r_outstanding >= 4'(MAX_OUTSTANDING))
                   || w_refresh_active;
  assign w_accept   = memrequest_en && !w_busy;
  assign w_complete = r_valid[LATENCY-1];

  // Memory write port; contents survive reset.
  always_ff @(posedge clk_dram_ctrl) begin
    if (w_accept && memrequest_write_enable) begin
      r_mem[w_idx] <= memrequest_write_data;
    end
  end

  // Read data sampled at acceptance (old contents) and shifted along the latency pipeline.
  always_ff @(posedge clk_dram_ctrl) begin
    r_data[0] <= r_mem[w_idx];
    for (int k = 1; k < LATENCY; k++) begin
      r_data[k] <= r_data[k-1];
    end
  end

  // Per-stage valid and write-type tags; reset drops every in-flight completion.
  always_ff @(posedge clk_dram_ctrl) begin
    if (!rst_dram_ctrl_n) begin
      r_valid <= '0;
      r_wr    <= '0;
    end else begin
      r_valid[0] <= w_accept;
      r_wr[0]    <= memrequest_write_enable;
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wr[k]    <= r_wr[k-1];
      end
    end
  end

  // In-flight counter: accept and complete in the same cycle cancel out.
  always_ff @(posedge clk_dram_ctrl) begin
    if (!rst_dram_ctrl_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_complete})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Sticky flag for an initiator that strobes en while busy.
  always_ff @(posedge clk_dram_ctrl) begin
    if (!rst_dram_ctrl_n) begin
      r_protocol_err <= 1'b0;
    end else if (memrequest_en && w_busy) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign memrequest_complete  = w_complete;
  assign memrequest_resp_data = (w_complete && !r_wr[LATENCY-1]) ? r_data[LATENCY-1] : '0;
  assign memrequest_busy      = w_busy;
  assign outstanding_count    = r_outstanding;
  assign protocol_err         = r_protocol_err;

endmodule

// File: tb/tb_memrequest_bram_responder.sv
// tb/tb_memrequest_bram_responder.sv - directed self-checking bench for memrequest_bram_responder
module tb_memrequest_bram_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [23:0]  addr;
  logic         en;
  logic [127:0] wdata;
  logic         we;
  logic [127:0] resp;
  logic         complete;
  logic         busy;
  logic [3:0]   count;
  logic         err;

  logic [23:0]  t_addr;
  logic         t_en;
  logic [127:0] t_wdata;
  logic         t_we;
  logic [127:0] t_resp;
  logic         t_complete;
  logic         t_busy;
  logic [3:0]   t_count;
  logic         t_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  memrequest_bram_responder #(
    .MEM_ADDR_BITS(17), .LATENCY(4), .MAX_OUTSTANDING(8)
  ) u_dut (
    .clk_dram_ctrl(clk), .rst_dram_ctrl_n(rst_n),
    .memrequest_addr(addr), .memrequest_en(en),
    .memrequest_write_data(wdata), .memrequest_write_enable(we),
    .memrequest_resp_data(resp), .memrequest_complete(complete),
    .memrequest_busy(busy), .outstanding_count(count), .protocol_err(err)
  );

  memrequest_bram_responder #(
    .MEM_ADDR_BITS(8), .LATENCY(4), .MAX_OUTSTANDING(2)
  ) u_thr (
    .clk_dram_ctrl(clk), .rst_dram_ctrl_n(rst_n),
    .memrequest_addr(t_addr), .memrequest_en(t_en),
    .memrequest_write_data(t_wdata), .memrequest_write_enable(t_we),
    .memrequest_resp_data(t_resp), .memrequest_complete(t_complete),
    .memrequest_busy(t_busy), .outstanding_count(t_count), .protocol_err(t_err)
  );

  function automatic logic [127:0] pat(input int i);
    return {4{32'h1000_0000 + 32'(i) * 32'h0101_0101}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    t_en = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    tick; tick;
    en = 1'b1;
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else n_pass++;
    tick;
    n_total++; if (complete !== 1'b0) $display("FAIL reset_complete got=%b exp=0", complete); else n_pass++;
    n_total++; if (resp !== 128'd0) $display("FAIL reset_resp got=%h exp=0", resp); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    en = 1'b0;
    rst_n = 1'b1;
    tick;
    n_total++; if (busy !== 1'b0) $display("FAIL release_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_write_read;
    en = 1'b1; we = 1'b1; addr = 24'h000010; wdata = {16{8'hA5}};
    tick;
    we = 1'b0; wdata = '0;
    tick;
    en = 1'b0;
    n_total++; if (count !== 4'd2) $display("FAIL wr_rd_count got=%0d exp=2", count); else n_pass++;
    n_total++; if (complete !== 1'b0) $display("FAIL wr_rd_early_t2 got=%b exp=0", complete); else n_pass++;
    tick;
    n_total++; if (complete !== 1'b0) $display("FAIL wr_rd_early_t3 got=%b exp=0", complete); else n_pass++;
    tick;
    n_total++; if (complete !== 1'b1) $display("FAIL wr_complete got=%b exp=1", complete); else n_pass++;
    n_total++; if (resp !== 128'd0) $display("FAIL wr_resp got=%h exp=0", resp); else n_pass++;
    tick;
    n_total++; if (complete !== 1'b1) $display("FAIL rd_complete got=%b exp=1", complete); else n_pass++;
    n_total++; if (resp !== {16{8'hA5}}) $display("FAIL rd_resp got=%h exp=%h", resp, {16{8'hA5}}); else n_pass++;
    tick;
    n_total++; if (complete !== 1'b0) $display("FAIL wr_rd_after got=%b exp=0", complete); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL wr_rd_drain got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic exp_c;
    logic [3:0] peak;
    for (int c = 0; c < 26; c++) begin
      en = (c < 20); we = 1'b1; addr = 24'(c); wdata = pat(c);
      exp_c = (c >= 4) && (c < 24);
      n_total++; if (complete !== exp_c) $display("FAIL b2b_wr_complete c=%0d got=%b exp=%b", c, complete, exp_c); else n_pass++;
      if (exp_c) begin
        n_total++; if (resp !== 128'd0) $display("FAIL b2b_wr_resp c=%0d got=%h exp=0", c, resp); else n_pass++;
      end
      tick;
    end
    peak = '0;
    for (int c = 0; c < 26; c++) begin
      en = (c < 20); we = 1'b0; addr = 24'(c); wdata = '0;
      exp_c = (c >= 4) && (c < 24);
      if (c < 20) begin
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy c=%0d got=%b exp=0", c, busy); else n_pass++;
      end
      n_total++; if (complete !== exp_c) $display("FAIL b2b_rd_complete c=%0d got=%b exp=%b", c, complete, exp_c); else n_pass++;
      if (exp_c) begin
        n_total++; if (resp !== pat(c - 4)) $display("FAIL b2b_rd_resp c=%0d got=%h exp=%h", c, resp, pat(c - 4)); else n_pass++;
      end
      if (count > peak) peak = count;
      tick;
    end
    en = 1'b0;
    n_total++; if (peak !== 4'd4) $display("FAIL b2b_peak got=%0d exp=4", peak); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL b2b_drain got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_alias;
    en = 1'b1; we = 1'b1; addr = 24'h020005; wdata = {4{32'hDEAD_BEEF}};
    tick;
    en = 1'b0; we = 1'b0; wdata = '0;
    repeat (5) tick;
    en = 1'b1; addr = 24'h000005;
    tick;
    en = 1'b0;
    tick; tick; tick;
    n_total++; if (complete !== 1'b1) $display("FAIL alias_complete got=%b exp=1", complete); else n_pass++;
    n_total++; if (resp !== {4{32'hDEAD_BEEF}}) $display("FAIL alias_resp got=%h exp=%h", resp, {4{32'hDEAD_BEEF}}); else n_pass++;
    tick;
    n_total++; if (complete !== 1'b0) $display("FAIL alias_single got=%b exp=0", complete); else n_pass++;
  endtask

  task automatic test_reset_inflight;
    en = 1'b1; we = 1'b1; addr = 24'h000030; wdata = {2{64'h0123_4567_89AB_CDEF}};
    tick;
    en = 1'b0; we = 1'b0; wdata = '0;
    repeat (5) tick;
    en = 1'b1;
    tick; tick; tick;
    en = 1'b0;
    n_total++; if (count !== 4'd3) $display("FAIL inflight_count got=%0d exp=3", count); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL inflight_rst_busy got=%b exp=1", busy); else n_pass++;
    tick;
    n_total++; if (count !== 4'd0) $display("FAIL inflight_rst_count got=%0d exp=0", count); else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_total++; if (complete !== 1'b0) $display("FAIL inflight_dropped c=%0d got=%b exp=0", c, complete); else n_pass++;
      tick;
    end
    en = 1'b1;
    tick;
    en = 1'b0;
    tick; tick; tick;
    n_total++; if (complete !== 1'b1) $display("FAIL retained_complete got=%b exp=1", complete); else n_pass++;
    n_total++; if (resp !== {2{64'h0123_4567_89AB_CDEF}}) $display("FAIL retained_resp got=%h exp=%h", resp, {2{64'h0123_4567_89AB_CDEF}}); else n_pass++;
    tick;
  endtask

  task automatic test_throttle;
    logic exp_b;
    for (int c = 0; c < 15; c++) begin
      t_en = !t_busy; t_we = 1'b0; t_addr = 24'(c);
      exp_b = ((c % 5) >= 2);
      n_total++; if (t_busy !== exp_b) $display("FAIL thr_busy c=%0d got=%b exp=%b", c, t_busy, exp_b); else n_pass++;
      n_total++; if (t_count > 4'd2) $display("FAIL thr_count c=%0d got=%0d exp<=2", c, t_count); else n_pass++;
      tick;
    end
    t_en = 1'b0;
    repeat (5) tick;
    n_total++; if (t_err !== 1'b0) $display("FAIL thr_err got=%b exp=0", t_err); else n_pass++;
    n_total++; if (t_count !== 4'd0) $display("FAIL thr_drain got=%0d exp=0", t_count); else n_pass++;
  endtask

  task automatic test_protocol_err;
    t_en = 1'b1;
    tick; tick; tick;
    t_en = 1'b0;
    n_total++; if (t_err !== 1'b1) $display("FAIL perr_set got=%b exp=1", t_err); else n_pass++;
    n_total++; if (t_count !== 4'd2) $display("FAIL perr_count got=%0d exp=2", t_count); else n_pass++;
    repeat (6) tick;
    n_total++; if (t_err !== 1'b1) $display("FAIL perr_sticky got=%b exp=1", t_err); else n_pass++;
    n_total++; if (t_count !== 4'd0) $display("FAIL perr_drain got=%0d exp=0", t_count); else n_pass++;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    n_total++; if (t_err !== 1'b0) $display("FAIL perr_clear got=%b exp=0", t_err); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_alias;
    test_reset_inflight;
    test_throttle;
    test_protocol_err;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
